// File: rtl/wb_traffic_if.sv
// wb_traffic_if
//   Wishbone B4 bus between wb_traffic_master and the SDRAM controller's
//   wb_* slave port.
//   Signals (named from the master's point of view):
//     wb_cyc_o, wb_stb_o, wb_we_o : cycle, strobe, write enable
//     wb_addr_o [AW]              : byte address
//     wb_dat_o  [DW]              : write data
//     wb_sel_o  [DW/8]            : byte selects
//     wb_cti_o  [3]               : cycle type identifier
//     wb_ack_i                    : acknowledge from the slave
//     wb_dat_i  [DW]              : read data from the slave
interface wb_traffic_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic [DW-1:0]   wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wb_traffic_master.sv
// wb_traffic_master
//   Wishbone B4 burst master: writes a programmable pattern over a region,
//   reads it back and counts mismatches. A watchdog aborts a stalled beat.
//   Ports:
//     sys_clk, RESETN      : clock, synchronous active-low reset
//     init_done            : controller init finished; start ignored while low
//     start                : one-cycle run request (ignored while busy)
//     cfg_mode/pattern/base_addr/burst_len/num_bursts/seed : run config,
//                            latched when a start is accepted
//     wb                   : Wishbone master modport
//     busy, done           : run in progress / one-cycle end-of-run pulse
//     err_flag, err_cnt, first_err_addr, timeout : run status
module wb_traffic_master #(
  parameter int DW  = 32,
  parameter int AW  = 32,
  parameter int BLW = 8,
  parameter int TMO = 1024
) (
  input  logic           sys_clk,
  input  logic           RESETN,
  input  logic           init_done,
  input  logic           start,
  input  logic [1:0]     cfg_mode,
  input  logic [1:0]     cfg_pattern,
  input  logic [AW-1:0]  cfg_base_addr,
  input  logic [BLW-1:0] cfg_burst_len,
  input  logic [15:0]    cfg_num_bursts,
  input  logic [DW-1:0]  cfg_seed,
  wb_traffic_if.master   wb,
  output logic           busy,
  output logic           done,
  output logic           err_flag,
  output logic [15:0]    err_cnt,
  output logic [AW-1:0]  first_err_addr,
  output logic           timeout
);
  localparam int BYTES = DW / 8;
  localparam int WDW   = $clog2(TMO + 1);

  typedef enum logic [2:0] {IDLE, WR_BURST, WR_GAP, RD_BURST, RD_GAP, FIN} state_t;
  state_t state, state_nxt;

  logic [1:0]     mode_q, pat_q;
  logic [AW-1:0]  base_q, addr_q;
  logic [BLW-1:0] blen_q, beat_cnt;
  logic [15:0]    nb_q, burst_cnt;
  logic [DW-1:0]  seed_q, inc_q, exp_data;
  logic [31:0]    lfsr_q;
  logic [WDW-1:0] wd_cnt;
  logic           accept, in_burst, beat_done, last_beat, phase_done;
  logic           wd_fire, restart_rd, mismatch;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Galois form, right shift; tap mask holds x^32, x^22, x^2, x^1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [31:0] lfsr_seed(input logic [DW-1:0] sd);
    logic [DW+31:0] e;
    e = {32'b0, sd};
    return (e[31:0] == 32'd0) ? 32'd1 : e[31:0];
  endfunction

  function automatic logic [DW-1:0] lfsr_rep(input logic [31:0] s);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = s[i % 32];
    return r;
  endfunction

  function automatic logic [DW-1:0] addr_data(input logic [AW-1:0] a);
    logic [AW+DW-1:0] e;
    e = {{DW{1'b0}}, a};
    return e[DW-1:0];
  endfunction

  always_comb begin
    unique case (pat_q)
      2'b00:   exp_data = inc_q;
      2'b01:   exp_data = addr_data(addr_q);
      2'b10:   exp_data = lfsr_rep(lfsr_q);
      default: exp_data = seed_q;
    endcase
  end

  assign accept     = (state == IDLE) && start && init_done;
  assign in_burst   = (state == WR_BURST) || (state == RD_BURST);
  assign beat_done  = in_burst && wb.wb_ack_i;
  assign last_beat  = (beat_cnt == blen_q - BLW'(1));
  // burst_cnt has already counted the burst that just ended when in a gap
  assign phase_done = (burst_cnt == nb_q);
  assign wd_fire    = in_burst && !wb.wb_ack_i && (wd_cnt == WDW'(TMO - 1));
  assign restart_rd = (state == WR_GAP) && phase_done && (mode_q != 2'b01);
  assign mismatch   = (state == RD_BURST) && wb.wb_ack_i && (wb.wb_dat_i != exp_data);

  always_ff @(posedge sys_clk) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    wb.wb_cyc_o     = in_burst;
    wb.wb_stb_o     = in_burst;
    wb.wb_we_o      = (state == WR_BURST);
    wb.wb_addr_o    = '0;
    wb.wb_dat_o     = '0;
    wb.wb_sel_o     = '0;
    wb.wb_cti_o     = 3'b000;
    busy            = (state != IDLE);
    done            = (state == FIN);
    if (in_burst) begin
      wb.wb_addr_o = addr_q;
      wb.wb_sel_o  = '1;
      wb.wb_cti_o  = last_beat ? 3'b111 : 3'b010;
      if (state == WR_BURST) wb.wb_dat_o = exp_data;
    end
    unique case (state)
      IDLE:     if (accept) state_nxt = (cfg_mode == 2'b10) ? RD_BURST : WR_BURST;
      WR_BURST: if (wd_fire) state_nxt = FIN;
                else if (beat_done && last_beat) state_nxt = WR_GAP;
      WR_GAP:   if (!phase_done) state_nxt = WR_BURST;
                else state_nxt = (mode_q == 2'b01) ? FIN : RD_BURST;
      RD_BURST: if (wd_fire) state_nxt = FIN;
                else if (beat_done && last_beat) state_nxt = RD_GAP;
      RD_GAP:   state_nxt = phase_done ? FIN : RD_BURST;
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!RESETN) begin
      beat_cnt  <= '0;
      burst_cnt <= '0;
      wd_cnt    <= '0;
    end else begin
      if (accept || restart_rd) begin
        beat_cnt  <= '0;
        burst_cnt <= '0;
      end else if (beat_done) begin
        if (last_beat) begin
          beat_cnt  <= '0;
          burst_cnt <= burst_cnt + 16'd1;
        end else begin
          beat_cnt <= beat_cnt + BLW'(1);
        end
      end
      wd_cnt <= (in_burst && !wb.wb_ack_i) ? wd_cnt + WDW'(1) : '0;
    end
  end

  // Pattern generator and latched configuration; only read while a run is active.
  always_ff @(posedge sys_clk) begin
    if (accept) begin
      mode_q <= cfg_mode;
      pat_q  <= cfg_pattern;
      base_q <= cfg_base_addr & ~AW'(BYTES - 1);
      addr_q <= cfg_base_addr & ~AW'(BYTES - 1);
      blen_q <= (cfg_burst_len == '0) ? BLW'(1) : cfg_burst_len;
      nb_q   <= (cfg_num_bursts == 16'd0) ? 16'd1 : cfg_num_bursts;
      seed_q <= cfg_seed;
      inc_q  <= cfg_seed;
      lfsr_q <= lfsr_seed(cfg_seed);
    end else if (restart_rd) begin
      addr_q <= base_q;
      inc_q  <= seed_q;
      lfsr_q <= lfsr_seed(seed_q);
    end else if (beat_done) begin
      addr_q <= addr_q + AW'(BYTES);
      inc_q  <= inc_q + DW'(1);
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!RESETN) begin
      err_flag       <= 1'b0;
      err_cnt        <= 16'd0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
    end else if (accept) begin
      err_flag       <= 1'b0;
      err_cnt        <= 16'd0;
      first_err_addr <= '0;
      timeout        <= 1'b0;
    end else begin
      if (mismatch) begin
        err_flag <= 1'b1;
        err_cnt  <= sat_inc16(err_cnt);
        if (!err_flag) first_err_addr <= addr_q;
      end
      if (wd_fire) timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_wb_traffic_master.sv
module tb_wb_traffic_master;
  localparam int DW = 32, AW = 32, BLW = 8, TMO = 16;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  cti;
  } beat_t;

  typedef struct packed {
    logic [15:0] err_cnt;
    logic [31:0] ferr;
    logic        flag;
    logic        tmo;
  } res_t;

  logic        clk = 1'b0, rstn = 1'b0, init_done = 1'b0, start = 1'b0;
  logic [1:0]  cfg_mode = 2'b00, cfg_pattern = 2'b00;
  logic [31:0] cfg_base_addr = 32'h0;
  logic [7:0]  cfg_burst_len = 8'h0;
  logic [15:0] cfg_num_bursts = 16'h0;
  logic [31:0] cfg_seed = 32'h0;
  logic        busy, done, err_flag, timeout;
  logic [15:0] err_cnt;
  logic [31:0] first_err_addr;

  int tests = 0, fails = 0;

  beat_t exp_beats[$];
  res_t  exp_res[$];

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        ack_en = 1'b1, slow = 1'b0, noack = 1'b0, corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = 32'h0;

  wb_traffic_if #(.DW(DW), .AW(AW)) wb ();

  wb_traffic_master #(.DW(DW), .AW(AW), .BLW(BLW), .TMO(TMO)) dut (
    .sys_clk        (clk),
    .RESETN         (rstn),
    .init_done      (init_done),
    .start          (start),
    .cfg_mode       (cfg_mode),
    .cfg_pattern    (cfg_pattern),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_burst_len  (cfg_burst_len),
    .cfg_num_bursts (cfg_num_bursts),
    .cfg_seed       (cfg_seed),
    .wb             (wb),
    .busy           (busy),
    .done           (done),
    .err_flag       (err_flag),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .timeout        (timeout)
  );

  always #5 clk = ~clk;

  // Slave: word memory, combinational ack gated by a per-cycle enable,
  // optional single-bit corruption of one address on the read path.
  assign wb.wb_ack_i = wb.wb_stb_o & ack_en;
  assign wb.wb_dat_i = mem[wb.wb_addr_o[11:2]] ^
                       ((corrupt_en && wb.wb_addr_o == corrupt_addr) ? 32'h100 : 32'h0);

  always @(posedge clk) begin
    if (wb.wb_stb_o && wb.wb_ack_i && wb.wb_we_o) mem[wb.wb_addr_o[11:2]] <= wb.wb_dat_o;
  end

  initial forever begin
    @(posedge clk);
    #1;
    ack_en = noack ? 1'b0 : (slow ? ($urandom_range(0, 2) != 0) : 1'b1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[31] = ~n[31];
      n[21] = ~n[21];
      n[1]  = ~n[1];
      n[0]  = ~n[0];
    end
    return n;
  endfunction

  // Reference model: list every bus beat of the run and the final status.
  task automatic build_expect(input logic [1:0] mode, input logic [1:0] pat,
                              input logic [31:0] base, input logic [7:0] blen,
                              input logic [15:0] nb, input logic [31:0] seed,
                              input bit corrupt, input logic [31:0] caddr,
                              input bit na, output int cyc);
    int bl, nbe, phases, nerr;
    logic [31:0] base_a, a, d, lf, src, ferr;
    logic [31:0] wr_data[$];
    beat_t b;
    res_t  r;
    bl = (blen == 8'd0) ? 1 : int'(blen);
    nbe = (nb == 16'd0) ? 1 : int'(nb);
    base_a = base & ~32'h3;
    phases = 0;
    nerr = 0;
    ferr = 32'h0;
    if (na) begin
      r.err_cnt = 16'h0; r.ferr = 32'h0; r.flag = 1'b0; r.tmo = 1'b1;
      exp_res.push_back(r);
      cyc = TMO + 1;
      return;
    end
    for (int p = 0; p < 2; p++) begin
      if ((p == 0 && mode == 2'b10) || (p == 1 && mode == 2'b01)) continue;
      phases++;
      lf = (seed == 32'h0) ? 32'h1 : seed;
      for (int k = 0; k < bl * nbe; k++) begin
        a = base_a + 32'(4 * k);
        case (pat)
          2'd0:    d = seed + 32'(k);
          2'd1:    d = a;
          2'd2:    d = lf;
          default: d = seed;
        endcase
        b.we = (p == 0);
        b.addr = a;
        b.data = d;
        b.cti = ((k % bl) == bl - 1) ? 3'b111 : 3'b010;
        exp_beats.push_back(b);
        if (p == 0) wr_data.push_back(d);
        else begin
          src = (mode != 2'b10) ? wr_data[k] : ref_mem[a[11:2]];
          if (corrupt && a == caddr) src = src ^ 32'h100;
          if (src != d) begin
            if (nerr == 0) ferr = a;
            nerr++;
          end
        end
        lf = lfsr_next(lf);
      end
    end
    r.err_cnt = 16'(nerr); r.ferr = ferr; r.flag = (nerr != 0); r.tmo = 1'b0;
    exp_res.push_back(r);
    cyc = phases * nbe * (bl + 1) + 1;
  endtask

  // Monitor: compares every acked beat and the status presented with done.
  initial forever begin
    beat_t e;
    res_t  r;
    @(negedge clk);
    if (rstn && wb.wb_stb_o && wb.wb_ack_i) begin
      if (exp_beats.size() == 0) begin
        tests++; fails++;
        $display("FAIL beat_unexpected: addr %0h we %0b", wb.wb_addr_o, wb.wb_we_o);
      end else begin
        e = exp_beats.pop_front();
        check("beat_we", wb.wb_we_o, e.we);
        check("beat_addr", wb.wb_addr_o, e.addr);
        check("beat_cti", wb.wb_cti_o, e.cti);
        check("beat_sel", wb.wb_sel_o, 4'hF);
        check("beat_cyc", wb.wb_cyc_o, 1'b1);
        if (e.we) begin
          check("beat_wdata", wb.wb_dat_o, e.data);
          ref_mem[e.addr[11:2]] = e.data;
        end
      end
    end
    if (rstn && done) begin
      if (exp_res.size() == 0) begin
        tests++; fails++;
        $display("FAIL done_unexpected: done 1, expected 0");
      end else begin
        r = exp_res.pop_front();
        check("res_err_cnt", err_cnt, r.err_cnt);
        check("res_err_flag", err_flag, r.flag);
        check("res_first_err_addr", first_err_addr, r.ferr);
        check("res_timeout", timeout, r.tmo);
        check("res_busy_in_fin", busy, 1'b1);
      end
    end
  end

  task automatic run(input logic [1:0] mode, input logic [1:0] pat, input logic [31:0] base,
                     input logic [7:0] blen, input logic [15:0] nb, input logic [31:0] seed,
                     input bit s_slow, input bit s_noack, input bit s_poke,
                     input bit s_corrupt, input logic [31:0] caddr);
    int exp_cyc, cycles, stbc;
    build_expect(mode, pat, base, blen, nb, seed, s_corrupt, caddr, s_noack, exp_cyc);
    slow = s_slow; noack = s_noack; corrupt_en = s_corrupt; corrupt_addr = caddr;
    @(negedge clk);
    cfg_mode = mode; cfg_pattern = pat; cfg_base_addr = base;
    cfg_burst_len = blen; cfg_num_bursts = nb; cfg_seed = seed;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    stbc = int'(wb.wb_stb_o);
    while (!done && cycles < 5000) begin
      start = s_poke && (cycles == 3);
      if (start) begin
        cfg_mode = ~mode; cfg_seed = ~seed; cfg_base_addr = base + 32'h40;
      end
      @(negedge clk);
      cycles++;
      if (wb.wb_stb_o) stbc++;
    end
    start = 1'b0;
    check("run_done", done, 1'b1);
    if (!s_slow || s_noack) check("run_cycles", cycles, exp_cyc);
    if (s_noack) check("stb_high_cycles", stbc, TMO);
    @(negedge clk);
    check("busy_after_run", busy, 1'b0);
    check("beats_left", exp_beats.size(), 0);
    noack = 1'b0; corrupt_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running");
    $fatal(1, "bench timeout");
  end

  initial begin
    int act, cyc_unused;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    repeat (3) @(negedge clk);
    check("rst_cyc", wb.wb_cyc_o, 1'b0);
    check("rst_stb", wb.wb_stb_o, 1'b0);
    check("rst_addr", wb.wb_addr_o, 32'h0);
    check("rst_dat", wb.wb_dat_o, 32'h0);
    check("rst_sel_cti", {wb.wb_sel_o, wb.wb_cti_o}, 7'h0);
    check("rst_status", {busy, done, err_flag, timeout, err_cnt, first_err_addr}, 52'h0);
    rstn = 1'b1;
    init_done = 1'b1;

    // zero-wait mode 00, incrementing, then same with a corrupted word
    run(2'b00, 2'b00, 32'h100, 8'd4, 16'd2, 32'h1234_5600, 0, 0, 0, 0, 32'h0);
    run(2'b00, 2'b00, 32'h100, 8'd4, 16'd2, 32'hA5A5_0000, 0, 0, 0, 1, 32'h108);
    // LFSR from a zero seed, single-beat bursts
    run(2'b00, 2'b10, 32'h300, 8'd1, 16'd3, 32'h0, 0, 0, 0, 0, 32'h0);
    // unaligned base, zero lengths, address pattern, mode 11
    run(2'b11, 2'b01, 32'h403, 8'd0, 16'd0, 32'h0, 0, 0, 0, 0, 32'h0);
    // read-only over the earlier region with a constant that does not match
    run(2'b10, 2'b11, 32'h100, 8'd3, 16'd2, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0);
    // slave never acks
    run(2'b00, 2'b00, 32'h500, 8'd4, 16'd2, 32'h1, 0, 1, 0, 0, 32'h0);

    // start while init_done is low must not start a run
    init_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    act = 0;
    repeat (8) begin
      if (wb.wb_cyc_o || wb.wb_stb_o || busy) act = 1;
      @(negedge clk);
    end
    check("no_run_without_init", act, 0);
    init_done = 1'b1;

    for (int i = 0; i < 8; i++) begin
      logic [31:0] b;
      b = 32'($urandom_range(0, 'h6ff));
      run(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), b,
          8'($urandom_range(0, 5)), 16'($urandom_range(0, 3)), $urandom,
          bit'($urandom_range(0, 1)), 0, bit'(i % 2), bit'($urandom_range(0, 1)),
          (b & ~32'h3) + 32'(4 * $urandom_range(0, 4)));
    end

    // reset during beat 2 of a write burst
    build_expect(2'b01, 2'b00, 32'h600, 8'd4, 16'd1, 32'h77, 0, 32'h0, 0, cyc_unused);
    slow = 1'b0;
    @(negedge clk);
    cfg_mode = 2'b01; cfg_pattern = 2'b00; cfg_base_addr = 32'h600;
    cfg_burst_len = 8'd4; cfg_num_bursts = 16'd1; cfg_seed = 32'h77;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_cyc_stb", {wb.wb_cyc_o, wb.wb_stb_o}, 2'b00);
    check("midrst_busy_done", {busy, done}, 2'b00);
    check("midrst_status", {err_flag, timeout, err_cnt, first_err_addr}, 50'h0);
    exp_beats.delete();
    exp_res.delete();
    @(negedge clk);
    rstn = 1'b1;

    run(2'b00, 2'b10, 32'h640, 8'd3, 16'd2, 32'hCAFE_F00D, 1, 0, 1, 1, 32'h644);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
